// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU front end.
package cpu_pkg;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
   localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP           = 32'd4;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch stage <-> hazard/branch/imem/decode signal bundle.
// Counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic [31:0] pc_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] redir_cnt_o;
   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      output imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o,
             fetch_cnt_o, stall_cnt_o, redir_cnt_o
   );
   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      input  imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o,
             fetch_cnt_o, stall_cnt_o, redir_cnt_o
   );
`else
   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      output imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o
   );
   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      input  imem_addr_o, pc_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o
   );
`endif
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: three saturating event counters (fetch, stall, redirect).
module fetch_perf_cnt (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        fetch_inc_i,
   input  logic        stall_inc_i,
   input  logic        redir_inc_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] redir_cnt_o
);
   logic [2:0][31:0] cnt_q, cnt_d;
   logic [2:0]       inc;
   assign inc = {redir_inc_i, stall_inc_i, fetch_inc_i};
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++)
         cnt_d[i] = (inc[i] && !(&cnt_q[i])) ? cnt_q[i] + 32'd1 : cnt_q[i];
   end
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign fetch_cnt_o = cnt_q[0];
   assign stall_cnt_o = cnt_q[1];
   assign redir_cnt_o = cnt_q[2];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem address and IF/ID register with stall, redirect and halt.
// Define FETCH_PERF_CNT_EN to add fetch/stall/redirect performance counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input logic           clk_i,
   input logic           rst_n,
   fetch_stage_if.master bus
);
   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic [31:0]  pc_plus4, target;
   assign pc_plus4 = pc_q + PC_STEP;
   assign target   = {bus.redirect_pc_i[31:2], 2'b00};
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN:
            if (bus.redirect_i) begin
               pc_d    = target;
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
            end else if (!bus.stall_i) begin
               if (bus.imem_instr_i == HALT_WORD) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
                  state_d = HALT;
               end else begin
                  pc_d    = pc_plus4;
                  instr_d = bus.imem_instr_i;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
               end
            end
         HALT:
            if (bus.redirect_i) begin
               pc_d    = target;
               state_d = RUN;
            end
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_n)
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= PC_RESET;
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   assign bus.pc_o         = pc_q;
   assign bus.imem_addr_o  = pc_q;
   assign bus.ifid_instr_o = instr_q;
   assign bus.ifid_pc4_o   = pc4_q;
   assign bus.ifid_valid_o = valid_q;
   assign bus.halted_o     = state_q == HALT;
`ifdef FETCH_PERF_CNT_EN
   logic run, fetch_inc, stall_inc, redir_inc;
   assign run       = state_q == RUN;
   assign fetch_inc = run && !bus.redirect_i && !bus.stall_i && bus.imem_instr_i != HALT_WORD;
   assign stall_inc = run && bus.stall_i && !bus.redirect_i;
   // BOOT ignores redirect, so only RUN/HALT redirects are counted
   assign redir_inc = state_q != BOOT && bus.redirect_i;
   fetch_perf_cnt u_perf (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .fetch_inc_i (fetch_inc),
      .stall_inc_i (stall_inc),
      .redir_inc_i (redir_inc),
      .fetch_cnt_o (bus.fetch_cnt_o),
      .stall_cnt_o (bus.stall_cnt_o),
      .redir_cnt_o (bus.redir_cnt_o)
   );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
   logic        clk_i = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;
   fetch_stage_if dif();
   fetch_stage dut (.clk_i(clk_i), .rst_n(rst_n), .bus(dif));
   always #5 clk_i = ~clk_i;
   assign dif.imem_instr_i = mem[dif.imem_addr_o[9:2]];
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask
   task automatic test_reset();
      dif.stall_i = 1'b0;
      dif.redirect_i = 1'b0;
      dif.redirect_pc_i = '0;
      #1 rst_n = 1'b0;
      tick();
      tick();
      checks++; if (dif.pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", dif.pc_o, 32'h0); end
      checks++; if (dif.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp %h", dif.ifid_instr_o, 32'h0); end
      checks++; if (dif.ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h0); end
      checks++; if (dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dif.ifid_valid_o); end
      checks++; if (dif.halted_o !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", dif.halted_o); end
      rst_n = 1'b1;
      tick();
      checks++; if (dif.pc_o !== 32'h0) begin errors++; $display("FAIL boot_pc got %h exp %h", dif.pc_o, 32'h0); end
      checks++; if (dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", dif.ifid_valid_o); end
   endtask
   task automatic test_sequential();
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2001_0005) begin errors++; $display("FAIL seq0_instr got %h exp %h", dif.ifid_instr_o, 32'h2001_0005); end
      checks++; if (dif.ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL seq0_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h4); end
      checks++; if (dif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b exp 1", dif.ifid_valid_o); end
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2002_0003) begin errors++; $display("FAIL seq1_instr got %h exp %h", dif.ifid_instr_o, 32'h2002_0003); end
      checks++; if (dif.ifid_pc4_o !== 32'h8) begin errors++; $display("FAIL seq1_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h8); end
      checks++; if (dif.pc_o !== 32'h8) begin errors++; $display("FAIL seq1_pc got %h exp %h", dif.pc_o, 32'h8); end
   endtask
   task automatic test_stall();
      dif.stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (dif.pc_o !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got %h exp %h", i, dif.pc_o, 32'h8); end
         checks++; if (dif.ifid_instr_o !== 32'h2002_0003) begin errors++; $display("FAIL stall_instr[%0d] got %h exp %h", i, dif.ifid_instr_o, 32'h2002_0003); end
         checks++; if (dif.ifid_pc4_o !== 32'h8) begin errors++; $display("FAIL stall_pc4[%0d] got %h exp %h", i, dif.ifid_pc4_o, 32'h8); end
         checks++; if (dif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, dif.ifid_valid_o); end
      end
      dif.stall_i = 1'b0;
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2222_2222) begin errors++; $display("FAIL resume_instr got %h exp %h", dif.ifid_instr_o, 32'h2222_2222); end
      checks++; if (dif.ifid_pc4_o !== 32'hC) begin errors++; $display("FAIL resume_pc4 got %h exp %h", dif.ifid_pc4_o, 32'hC); end
      checks++; if (dif.pc_o !== 32'hC) begin errors++; $display("FAIL resume_pc got %h exp %h", dif.pc_o, 32'hC); end
   endtask
   task automatic test_redirect();
      dif.stall_i = 1'b1;
      dif.redirect_i = 1'b1;
      dif.redirect_pc_i = 32'h40;
      tick();
      checks++; if (dif.pc_o !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp %h", dif.pc_o, 32'h40); end
      checks++; if (dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", dif.ifid_valid_o); end
      checks++; if (dif.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL redir_instr got %h exp %h", dif.ifid_instr_o, 32'h0); end
      dif.stall_i = 1'b0;
      dif.redirect_i = 1'b0;
      tick();
      checks++; if (dif.ifid_instr_o !== 32'hAAAA_0001) begin errors++; $display("FAIL target_instr got %h exp %h", dif.ifid_instr_o, 32'hAAAA_0001); end
      checks++; if (dif.ifid_pc4_o !== 32'h44) begin errors++; $display("FAIL target_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h44); end
      checks++; if (dif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL target_valid got %b exp 1", dif.ifid_valid_o); end
      dif.redirect_i = 1'b1;
      dif.redirect_pc_i = 32'h43;
      tick();
      checks++; if (dif.pc_o !== 32'h40) begin errors++; $display("FAIL align_pc got %h exp %h", dif.pc_o, 32'h40); end
      checks++; if (dif.imem_addr_o !== 32'h40) begin errors++; $display("FAIL align_addr got %h exp %h", dif.imem_addr_o, 32'h40); end
      dif.redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      dif.redirect_i = 1'b0;
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h5555_5555) begin errors++; $display("FAIL wrap_instr got %h exp %h", dif.ifid_instr_o, 32'h5555_5555); end
      checks++; if (dif.ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h0); end
      checks++; if (dif.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", dif.pc_o, 32'h0); end
   endtask
   task automatic test_halt();
      mem[3] = 32'hFFFF_FFFF;
      dif.redirect_i = 1'b1;
      dif.redirect_pc_i = 32'hC;
      tick();
      dif.redirect_pc_i = 32'h40;
      tick();
      checks++; if (dif.pc_o !== 32'h40) begin errors++; $display("FAIL halt_prio_pc got %h exp %h", dif.pc_o, 32'h40); end
      checks++; if (dif.halted_o !== 1'b0) begin errors++; $display("FAIL halt_prio_halted got %b exp 0", dif.halted_o); end
      dif.redirect_pc_i = 32'h8;
      tick();
      dif.redirect_i = 1'b0;
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2222_2222) begin errors++; $display("FAIL pre_halt_instr got %h exp %h", dif.ifid_instr_o, 32'h2222_2222); end
      tick();
      checks++; if (dif.halted_o !== 1'b1) begin errors++; $display("FAIL halt_rise got %b exp 1", dif.halted_o); end
      checks++; if (dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_valid got %b exp 0", dif.ifid_valid_o); end
      checks++; if (dif.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL halt_instr got %h exp %h", dif.ifid_instr_o, 32'h0); end
      for (int i = 0; i < 10; i++) begin
         dif.stall_i = i[0];
         tick();
         checks++; if (dif.pc_o !== 32'hC || dif.halted_o !== 1'b1 || dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL halt_hold[%0d] got pc %h halted %b valid %b exp pc %h halted 1 valid 0", i, dif.pc_o, dif.halted_o, dif.ifid_valid_o, 32'hC); end
      end
      dif.stall_i = 1'b0;
      dif.redirect_i = 1'b1;
      dif.redirect_pc_i = 32'h0;
      tick();
      checks++; if (dif.halted_o !== 1'b0) begin errors++; $display("FAIL unhalt got %b exp 0", dif.halted_o); end
      checks++; if (dif.pc_o !== 32'h0) begin errors++; $display("FAIL unhalt_pc got %h exp %h", dif.pc_o, 32'h0); end
      dif.redirect_i = 1'b0;
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2001_0005) begin errors++; $display("FAIL unhalt_instr got %h exp %h", dif.ifid_instr_o, 32'h2001_0005); end
      checks++; if (dif.pc_o !== 32'h4) begin errors++; $display("FAIL unhalt_next_pc got %h exp %h", dif.pc_o, 32'h4); end
   endtask
   task automatic test_reset_mid_run();
      dif.redirect_i = 1'b1;
      dif.redirect_pc_i = 32'h1C;
      tick();
      dif.redirect_i = 1'b0;
      tick();
      checks++; if (dif.pc_o !== 32'h20 || dif.ifid_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre got pc %h valid %b exp pc %h valid 1", dif.pc_o, dif.ifid_valid_o, 32'h20); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (dif.pc_o !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h exp %h", dif.pc_o, 32'h0); end
      checks++; if (dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", dif.ifid_valid_o); end
      checks++; if (dif.ifid_pc4_o !== 32'h0) begin errors++; $display("FAIL mid_rst_pc4 got %h exp %h", dif.ifid_pc4_o, 32'h0); end
      checks++; if (dif.ifid_instr_o !== 32'h0) begin errors++; $display("FAIL mid_rst_instr got %h exp %h", dif.ifid_instr_o, 32'h0); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (dif.fetch_cnt_o !== 32'h0) begin errors++; $display("FAIL cnt_fetch got %h exp 0", dif.fetch_cnt_o); end
      checks++; if (dif.stall_cnt_o !== 32'h0) begin errors++; $display("FAIL cnt_stall got %h exp 0", dif.stall_cnt_o); end
      checks++; if (dif.redir_cnt_o !== 32'h0) begin errors++; $display("FAIL cnt_redir got %h exp 0", dif.redir_cnt_o); end
`endif
      #1 rst_n = 1'b1;
      tick();
      checks++; if (dif.pc_o !== 32'h0 || dif.ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reboot got pc %h valid %b exp pc 0 valid 0", dif.pc_o, dif.ifid_valid_o); end
      tick();
      checks++; if (dif.ifid_instr_o !== 32'h2001_0005) begin errors++; $display("FAIL reboot_instr got %h exp %h", dif.ifid_instr_o, 32'h2001_0005); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (dif.fetch_cnt_o !== 32'h1) begin errors++; $display("FAIL cnt_fetch1 got %h exp 1", dif.fetch_cnt_o); end
`endif
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]   = 32'h2001_0005;
      mem[1]   = 32'h2002_0003;
      mem[2]   = 32'h2222_2222;
      mem[3]   = 32'h3333_3333;
      mem[16]  = 32'hAAAA_0001;
      mem[17]  = 32'hAAAA_0002;
      mem[255] = 32'h5555_5555;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_halt();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
